// File: rtl/ita_package.sv
// Shared ITA types and constants used by the activation output buffer.
// Provides requant_oup_t, ACT_LATENCY and the buffered entry layout.
package ita_package;

  localparam int unsigned N           = 4;
  localparam int unsigned WO          = 8;
  localparam int unsigned ACT_LATENCY = 2;

  typedef logic [N-1:0][WO-1:0] requant_oup_t;

  typedef struct packed {
    requant_oup_t data;
    logic         last;
  } outbuf_entry_t;

endpackage

// File: rtl/ita_outbuf_fifo.sv
// Circular FIFO, any DEPTH >= 2, async active-high reset.
// Ports: clk_i, rst_i, push_i/data_i, pop_i, data_o (0 when empty), count_o, empty_o.
module ita_outbuf_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count;
  // Gate the head so a cleared FIFO presents zero, not stale storage.
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({push_i, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i) !(push_i && full)
  );

endmodule

// File: rtl/ita_act_outbuf.sv
// Activation output buffer: tracks issued words through the activation
// latency and parks results in a credit-protected FIFO.
// Ports: clk_i, rst_i, valid_i/last_i/ready_o (issue), act_data_i,
// valid_o/ready_i/data_o/last_o (downstream); stall_cnt_o only when
// ITA_ACT_OUTBUF_PERF_EN is defined.
module ita_act_outbuf
  import ita_package::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = ACT_LATENCY
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic         last_i,
  output logic         ready_o,
  input  requant_oup_t act_data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output requant_oup_t data_o,
  output logic         last_o
`ifdef ITA_ACT_OUTBUF_PERF_EN
  ,
  output logic [31:0]  stall_cnt_o
`endif
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = $bits(outbuf_entry_t);
  localparam logic [31:0] DEPTH_L = DEPTH;

  if (LATENCY < 1 || DEPTH < LATENCY + 1) begin : g_bad_cfg
    $fatal(1, "ita_act_outbuf: need LATENCY>=1 and DEPTH>=LATENCY+1");
  end

  logic [LATENCY-1:0] vld_pipe;
  logic [LATENCY-1:0] last_pipe;
  logic               issue;
  logic               write;
  logic               pop;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [31:0]        occ;
  outbuf_entry_t      wr_entry;
  outbuf_entry_t      head;
  logic [ENTRY_W-1:0] head_raw;

  assign issue = valid_i & ready_o;
  assign write = vld_pipe[LATENCY-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= (vld_pipe << 1) | LATENCY'(issue);
      last_pipe <= (last_pipe << 1) | LATENCY'(issue & last_i);
    end
  end

  // Every word in flight already owns a FIFO slot, so the FIFO can
  // never overflow and ready_o needs no view of ready_i.
  assign occ     = 32'(count) + 32'($countones(vld_pipe));
  assign ready_o = occ < DEPTH_L;

  assign wr_entry.data = act_data_i;
  assign wr_entry.last = last_pipe[LATENCY-1];

  ita_outbuf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (write),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .data_o  (head_raw),
    .count_o (count),
    .empty_o (empty)
  );

  assign head    = head_raw;
  assign valid_o = ~empty;
  assign pop     = valid_o & ready_i;
  assign data_o  = head.data;
  assign last_o  = head.last;

`ifdef ITA_ACT_OUTBUF_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (valid_o && !ready_i && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ita_act_outbuf.sv
// Randomized bench for ita_act_outbuf against a word-queue model.
// Two instances: DEPTH=4 (main) and DEPTH=3 (wrap case).
module tb_ita_act_outbuf;
  import ita_package::*;

  localparam int L = ACT_LATENCY;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, valid, last, rdy, sel;
  requant_oup_t act;
  logic         va, vb;
  logic         ready_a, ready_b, valid_a, valid_b, last_a, last_b;
  requant_oup_t data_a, data_b;
  logic         m_ready, m_valid, m_last;
  requant_oup_t m_data;
`ifdef ITA_ACT_OUTBUF_PERF_EN
  logic [31:0]  stall_a, stall_b, m_stall;
`endif

  assign va = valid & ~sel;
  assign vb = valid & sel;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_last  = sel ? last_b  : last_a;
  assign m_data  = sel ? data_b  : data_a;
`ifdef ITA_ACT_OUTBUF_PERF_EN
  assign m_stall = sel ? stall_b : stall_a;
`endif

  ita_act_outbuf #(.DEPTH(4), .LATENCY(L)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(va), .last_i(last),
    .ready_o(ready_a), .act_data_i(act), .valid_o(valid_a),
    .ready_i(rdy), .data_o(data_a), .last_o(last_a)
`ifdef ITA_ACT_OUTBUF_PERF_EN
    , .stall_cnt_o(stall_a)
`endif
  );

  ita_act_outbuf #(.DEPTH(3), .LATENCY(L)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .valid_i(vb), .last_i(last),
    .ready_o(ready_b), .act_data_i(act), .valid_o(valid_b),
    .ready_i(rdy), .data_o(data_b), .last_o(last_b)
`ifdef ITA_ACT_OUTBUF_PERF_EN
    , .stall_cnt_o(stall_b)
`endif
  );

  typedef struct {
    int           cyc;
    requant_oup_t data;
    logic         last;
  } word_t;

  word_t q[$];
  int cyc, depth, total, bad, stalls, issued;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: model says a word sits in the system from issue until
  // popped, and is visible at the head LATENCY+1 cycles after issue.
  task automatic step(input logic v, input logic l, input logic r);
    word_t        w;
    logic         exp_rdy, exp_vld, iss, pop;
    requant_oup_t a;
    a = $urandom;
    foreach (q[k]) if (q[k].cyc == cyc - L) a = q[k].data;
    act = a; valid = v; last = l; rdy = r;
    #1;
    exp_rdy = (q.size() < depth);
    exp_vld = (q.size() != 0) && (cyc - q[0].cyc >= L + 1);
    check("ready_o", 64'(m_ready), 64'(exp_rdy));
    check("valid_o", 64'(m_valid), 64'(exp_vld));
    if (exp_vld) begin
      check("data_o", 64'(m_data), 64'(q[0].data));
      check("last_o", 64'(m_last), 64'(q[0].last));
    end else begin
      check("idle_data", 64'(m_data), 64'd0);
    end
    iss = v & exp_rdy;
    pop = exp_vld & r;
    if (exp_vld & ~r) stalls++;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (iss) begin
      w.cyc = cyc; w.data = $urandom; w.last = l;
      q.push_back(w);
      issued++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; rdy = 1'b0; last = 1'b0;
    #1;
    q.delete();
    stalls = 0;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_ready", 64'(m_ready), 64'd1);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
`ifdef ITA_ACT_OUTBUF_PERF_EN
    check("rst_stall", 64'(m_stall), 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    int n0, guard;
    total = 0; bad = 0; cyc = 0; issued = 0; stalls = 0;
    rst = 1'b1; valid = 1'b0; last = 1'b0; rdy = 1'b0; act = '0;
    sel = 1'b0; depth = 4;
    @(negedge clk);
    do_reset();

    // streaming: 16 back-to-back, ready held high
    n0 = issued;
    for (int i = 0; i < 16; i++) step(1'b1, i == 15, 1'b1);
    check("stream_issues", 64'(issued - n0), 64'd16);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);

    // backpressure, then one-cycle release
    n0 = issued;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    check("bp_issues", 64'(issued - n0), 64'd4);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    check("release_issues", 64'(issued - n0), 64'd5);
`ifdef ITA_ACT_OUTBUF_PERF_EN
    check("bp_stalls", 64'(m_stall), 64'(stalls));
`endif
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);

    // exactly 7 stall cycles
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
`ifdef ITA_ACT_OUTBUF_PERF_EN
    check("stall7", 64'(m_stall), 64'd7);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

    // reset with words buffered and in flight
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom));

    // random mix
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom));
`ifdef ITA_ACT_OUTBUF_PERF_EN
    check("mix_stalls", 64'(m_stall), 64'(stalls));
`endif

    // wrap on DEPTH=3, last tagged on word 9
    sel = 1'b1; depth = 3;
    do_reset();
    n0 = issued; guard = 0;
    while (issued - n0 < 10 && guard < 300) begin
      step(1'($urandom), (issued - n0) == 9, 1'($urandom));
      guard++;
    end
    check("wrap_issues", 64'(issued - n0), 64'd10);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
    check("wrap_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
